alu_result_stage: RTL

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// ALU result stage: a small FIFO that decouples the ALU from its consumer.
// Each entry carries {opcode, flags, result}. The stage also keeps sticky
// status: the OR of the flags of every accepted entry since the last clear,
// and a saturating count of accepted divide-by-zero results.
`timescale 1ns/1ps

module alu_result_stage #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4   // power of two, at least 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   // upstream ALU side
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [3:0]                 in_opcode,
   input  logic [WIDTH-1:0]           in_result,
   input  logic                       in_zero,
   input  logic                       in_carry,
   input  logic                       in_overflow,
   input  logic                       in_negative,
   input  logic                       in_div_by_zero,
   // consumer side
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_result,
   output logic [3:0]                 out_opcode,
   output logic [4:0]                 out_flags,
   // sticky status
   input  logic                       sticky_clr,
   output logic [4:0]                 sticky_flags,
   output logic [7:0]                 dbz_count,
   output logic [$clog2(DEPTH):0]     out_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   // entry layout: [EW-1 -: 4] opcode, [WIDTH+4 : WIDTH] flags, [WIDTH-1:0] result
   localparam int EW = 4 + 5 + WIDTH;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [7:0]    DBZ_MAX    = 8'hFF;

   // pointer / occupancy state
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // sticky status state
   logic [4:0]    sticky_q, sticky_d;
   logic [7:0]    dbz_q, dbz_d;

   // handshakes and entry formatting
   logic          push;
   logic          pop;
   logic          not_empty;
   logic [4:0]    in_flags;
   logic [EW-1:0] wr_entry;
   logic [EW-1:0] head_entry;
   logic [EW-1:0] entry_arr [DEPTH];

   // flags packed with zero in bit 0, div_by_zero in bit 4
   assign in_flags = {in_div_by_zero, in_negative, in_overflow, in_carry, in_zero};
   assign wr_entry = {in_opcode, in_flags, in_result};

   // ready depends only on occupancy, never on out_ready, so a full FIFO
   // refuses a push even when a pop happens in the same cycle
   assign in_ready  = (count_q != FULL_COUNT);
   assign not_empty = (count_q != '0);
   assign out_valid = not_empty;

   assign push = in_valid & in_ready;
   assign pop  = not_empty & out_ready;

   // Storage: one register per entry, no reset needed. The write strobe
   // decodes the write pointer so each entry has exactly one driver.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [EW-1:0] entry_q;

         // capture the incoming entry when this slot is the write target
         always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == AW'(gi))) begin
               entry_q <= wr_entry;
            end
         end

         assign entry_arr[gi] = entry_q;
      end
   endgenerate

   // Head entry comes straight from storage at the read pointer, so there is
   // no path from in_* to out_*. Gating with not_empty keeps the outputs at
   // zero after reset while storage still holds stale or unknown contents.
   assign head_entry = not_empty ? entry_arr[rd_ptr_q] : '0;
   assign out_result = head_entry[WIDTH-1:0];
   assign out_flags  = head_entry[WIDTH+4:WIDTH];
   assign out_opcode = head_entry[EW-1:EW-4];

   assign out_count    = count_q;
   assign sticky_flags = sticky_q;
   assign dbz_count    = dbz_q;

   // next-state for pointers and occupancy; pointers wrap naturally at DEPTH
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // next-state for sticky status; a clear in the same cycle as a push
   // keeps only the pushed contribution
   always_comb begin
      sticky_d = sticky_q;
      dbz_d    = dbz_q;
      if (sticky_clr) begin
         sticky_d = push ? in_flags : 5'b0;
         dbz_d    = (push && in_div_by_zero) ? 8'd1 : 8'd0;
      end else if (push) begin
         sticky_d = sticky_q | in_flags;
         if (in_div_by_zero && (dbz_q != DBZ_MAX)) begin
            dbz_d = dbz_q + 8'd1;
         end
      end
   end

   // control registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         sticky_q <= '0;
         dbz_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         sticky_q <= sticky_d;
         dbz_q    <= dbz_d;
      end
   end

endmodule
